// File: rtl/event_packer_if.sv
// event_packer_if -- handshake/bus bundle between the event packer, the
// first-word-fall-through capture FIFO and the 16-bit readout FIFO.
//
// Signals:
//   evt_valid  capture FIFO non-empty, evt_data is valid
//   evt_data   256-bit event, 32 byte slots (8'hFF = no hit)
//   evt_rd_en  one-cycle pop strobe to the capture FIFO
//   out_full   readout FIFO full (registered by the FIFO)
//   out_wr_en  write strobe to the readout FIFO
//   out_data   readout word, valid while out_wr_en=1
//   busy       packer is working on an event
//
// Modports:
//   master  the packer side
//   slave   the FIFO/environment side
interface event_packer_if;
  logic         evt_valid;
  logic [255:0] evt_data;
  logic         evt_rd_en;
  logic         out_full;
  logic         out_wr_en;
  logic [15:0]  out_data;
  logic         busy;

  modport master (
    input  evt_valid, evt_data, out_full,
    output evt_rd_en, out_wr_en, out_data, busy
  );

  modport slave (
    output evt_valid, evt_data, out_full,
    input  evt_rd_en, out_wr_en, out_data, busy
  );
endinterface

// File: rtl/event_packer.sv
// event_packer -- pops one 256-bit event from a FWFT capture FIFO and writes
// a header word, one hit word per examined slot and a trailer word into a
// 16-bit readout FIFO.
//
// Ports:
//   clk100  sole clock, rising edge
//   rst     synchronous, active-high reset
//   bus     event_packer_if.master (evt_*, out_*, busy)
//
// Build option:
//   ZERO_SUPPRESS_EN  when defined, slots equal to 8'hFF emit no word
//                     (still one cycle each); otherwise every slot emits.
//
// state   | meaning
// IDLE    | waiting for evt_valid; pops and latches the event
// HEADER  | writing {4'hA, 4'h0, evt_cnt}
// SCAN    | one slot per cycle, slot 0 .. 31
// TRAILER | writing {4'hE, 6'b0, nhits}, then back to IDLE
module event_packer (
  input  logic           clk100,
  input  logic           rst,
  event_packer_if.master bus
);

  typedef enum logic [1:0] {IDLE, HEADER, SCAN, TRAILER} state_t;

  state_t         state;
  logic [255:0]   evt_q;
  logic [7:0]     evt_cnt;
  logic [5:0]     nhits;
  logic [4:0]     slot;
  logic [15:0]    out_q;

  logic [7:0]     slot_val;
  logic [3:0]     slot_tag;
  logic           word_due;
  logic [15:0]    word;
  logic           write;

  always_comb begin
    slot_val = evt_q[{slot, 3'b000} +: 8];
    case (slot[4:3])
      2'd0:    slot_tag = 4'hC;
      2'd1:    slot_tag = 4'hD;
      2'd2:    slot_tag = 4'h2;
      default: slot_tag = 4'h3;
    endcase
  end

  always_comb begin
    word_due = 1'b0;
    word     = 16'h0000;
    case (state)
      HEADER: begin
        word_due = 1'b1;
        word     = {4'hA, 4'h0, evt_cnt};
      end
      SCAN: begin
`ifdef ZERO_SUPPRESS_EN
        word_due = (slot_val != 8'hFF);
`else
        word_due = 1'b1;
`endif
        word     = {slot_tag, 1'b0, slot[2:0], slot_val};
      end
      TRAILER: begin
        word_due = 1'b1;
        word     = {4'hE, 6'b000000, nhits};
      end
      default: begin
        word_due = 1'b0;
        word     = 16'h0000;
      end
    endcase
  end

  // The full flag is already registered by the FIFO, so the write decision
  // is made on it directly in the same cycle; a blocked word simply waits
  // because nothing below advances without a write.
  assign write         = word_due & ~bus.out_full & ~rst;
  assign bus.out_wr_en = write;
  // out_data shows the new word only on the write cycle and otherwise keeps
  // the last word written, so it is also stable while a word is held.
  assign bus.out_data  = rst ? 16'h0000 : (write ? word : out_q);
  assign bus.evt_rd_en = (state == IDLE) & bus.evt_valid & ~rst;
  assign bus.busy      = (state != IDLE) & ~rst;

  always_ff @(posedge clk100) begin
    if (rst) begin
      state   <= IDLE;
      evt_q   <= '0;
      evt_cnt <= 8'h00;
      nhits   <= 6'd0;
      slot    <= 5'd0;
      out_q   <= 16'h0000;
    end else begin
      if (write) begin
        out_q <= word;
      end
      case (state)
        IDLE: begin
          if (bus.evt_valid) begin
            evt_q <= bus.evt_data;
            state <= HEADER;
          end
        end
        HEADER: begin
          if (write) begin
            slot  <= 5'd0;
            state <= SCAN;
          end
        end
        SCAN: begin
          // Suppressed slots (no word due) advance unconditionally.
          if (write || !word_due) begin
            if (write) begin
              nhits <= nhits + 6'd1;
            end
            slot <= slot + 5'd1;
            if (slot == 5'd31) begin
              state <= TRAILER;
            end
          end
        end
        TRAILER: begin
          if (write) begin
            nhits   <= 6'd0;
            evt_cnt <= evt_cnt + 8'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_packer.sv
module tb_event_packer;

`ifdef ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk100;
  logic rst;

  event_packer_if bus ();

  event_packer dut (
    .clk100 (clk100),
    .rst    (rst),
    .bus    (bus)
  );

  initial begin
    clk100 = 1'b0;
    forever #5 clk100 = ~clk100;
  end

  int cyc = 0;
  always @(posedge clk100) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  // Source FIFO contents, expected readout stream, and a log of writes seen.
  logic [255:0] src_q [$];
  logic [15:0]  exp_q [$];
  logic [15:0]  wlog  [$];
  logic [15:0]  hdr_log [$];
  logic [7:0]   mcnt = 8'h00;
  logic [15:0]  last_data = 16'h0000;
  logic         rd_seen = 1'b0;
  int           pop_count = 0;
  int           last_pop = 0;
  bit           stream_mode = 1'b0;
  int           stream_pops = 0;

  logic [3:0] tag_tbl [4] = '{4'hC, 4'hD, 4'h2, 4'h3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whole-event model: header, one word per reported slot, trailer.
  function automatic void model_event(input logic [255:0] d);
    int         n;
    logic [7:0] v;
    logic [4:0] kk;
    exp_q.push_back({8'hA0, mcnt});
    n = 0;
    for (int k = 0; k < 32; k++) begin
      v  = d[8*k +: 8];
      kk = k[4:0];
      if (!ZS || v != 8'hFF) begin
        exp_q.push_back({tag_tbl[k/8], 1'b0, kk[2:0], v});
        n++;
      end
    end
    exp_q.push_back({4'hE, 6'b000000, n[5:0]});
    mcnt = mcnt + 8'd1;
  endfunction

  // Capture FIFO emulation: pops after a sampled evt_rd_en.
  always @(posedge clk100) begin
    #1;
    if (rd_seen) begin
      rd_seen = 1'b0;
      if (src_q.size() == 0) begin
        chk("pop_when_empty", 32'd1, 32'd0);
      end else begin
        model_event(src_q.pop_front());
        if (stream_mode) begin
          if (stream_pops > 0) chk("pop_spacing", cyc - 1 - last_pop, 32'd35);
          stream_pops++;
        end
        last_pop = cyc - 1;
        pop_count++;
      end
    end
    bus.evt_valid = (src_q.size() != 0);
    bus.evt_data  = (src_q.size() != 0) ? src_q[0] : '0;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk100) begin
    if (rst) begin
      chk("rst_rd_en", bus.evt_rd_en, 32'd0);
      chk("rst_wr_en", bus.out_wr_en, 32'd0);
      chk("rst_busy",  bus.busy,      32'd0);
      chk("rst_data",  bus.out_data,  32'd0);
      exp_q.delete();
      mcnt      = 8'h00;
      last_data = 16'h0000;
      rd_seen   = 1'b0;
    end else begin
      chk("busy", bus.busy, (exp_q.size() != 0) ? 32'd1 : 32'd0);
      chk("rd_en", bus.evt_rd_en, (bus.evt_valid && exp_q.size() == 0) ? 32'd1 : 32'd0);
      rd_seen = bus.evt_rd_en;
      if (bus.out_full) chk("wr_while_full", bus.out_wr_en, 32'd0);
      if (bus.out_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {16'h0, bus.out_data}, 32'hDEAD_0000);
        end else begin
          chk("word", bus.out_data, exp_q.pop_front());
        end
        last_data = bus.out_data;
        wlog.push_back(bus.out_data);
        if (bus.out_data[15:12] == 4'hA) hdr_log.push_back(bus.out_data);
      end else begin
        chk("hold_data", bus.out_data, last_data);
      end
    end
  end

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk100);
      if (src_q.size() == 0 && exp_q.size() == 0 && !bus.busy && !bus.evt_valid) return;
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_pop(input int budget, input string name);
    int pc0;
    pc0 = pop_count;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk100);
      #2;
      if (pop_count != pc0) return;
    end
    chk({name, "_pop_timeout"}, 32'd1, 32'd0);
  endtask

  function automatic logic [255:0] all_ff();
    return {32{8'hFF}};
  endfunction

  logic [255:0] ev;
  int base;
  int pc;

  initial begin
    rst          = 1'b1;
    bus.out_full = 1'b0;
    repeat (3) @(posedge clk100);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk100);

    // Sparse event: only slots 0 and 31 hold hits.
    ev = all_ff();
    ev[7:0]     = 8'h12;
    ev[255:248] = 8'h7F;
    base = wlog.size();
    pc   = pop_count;
    #1 src_q.push_back(ev);
    wait_idle(200, "sparse");
    chk("sparse_pops", pop_count - pc, 32'd1);
`ifdef ZERO_SUPPRESS_EN
    chk("sparse_len", wlog.size() - base, 32'd4);
    chk("sparse_w0", wlog[base],   32'h0000A000);
    chk("sparse_w1", wlog[base+1], 32'h0000C012);
    chk("sparse_w2", wlog[base+2], 32'h0000377F);
    chk("sparse_w3", wlog[base+3], 32'h0000E002);
`else
    chk("sparse_len", wlog.size() - base, 32'd34);
    chk("sparse_w0",  wlog[base],    32'h0000A000);
    chk("sparse_w1",  wlog[base+1],  32'h0000C012);
    chk("sparse_w32", wlog[base+32], 32'h0000377F);
    chk("sparse_w33", wlog[base+33], 32'h0000E020);
`endif

    // Event with every slot empty.
    base = wlog.size();
    @(posedge clk100);
    #1 src_q.push_back(all_ff());
    wait_idle(200, "allff");
`ifdef ZERO_SUPPRESS_EN
    chk("allff_len", wlog.size() - base, 32'd2);
    chk("allff_hdr", wlog[base],   32'h0000A001);
    chk("allff_trl", wlog[base+1], 32'h0000E000);
`else
    chk("allff_len",   wlog.size() - base, 32'd34);
    chk("allff_hdr",   wlog[base],    32'h0000A001);
    chk("allff_slot9", wlog[base+10], 32'h0000D1FF);
    chk("allff_trl",   wlog[base+33], 32'h0000E020);
`endif

    // Backpressure while the slot-10 word is due.
    for (int k = 0; k < 32; k++) ev[8*k +: 8] = 8'(8'h10 + k);
    ev[8*5  +: 8] = 8'hFF;
    ev[8*20 +: 8] = 8'hFF;
    ev[8*10 +: 8] = 8'h40;
    base = wlog.size();
    @(posedge clk100);
    #1 src_q.push_back(ev);
    wait_pop(20, "bp");
    repeat (11) @(posedge clk100);
    #1 bus.out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk100);
      chk("bp_wr_low", bus.out_wr_en, 32'd0);
      @(posedge clk100);
    end
    #1 bus.out_full = 1'b0;
    @(negedge clk100);
    chk("bp_write", {15'h0, bus.out_wr_en, bus.out_data}, 32'h0001D240);
    wait_idle(200, "bp");
`ifdef ZERO_SUPPRESS_EN
    chk("bp_len", wlog.size() - base, 32'd32);
    chk("bp_trl", wlog[base+31], 32'h0000E01E);
`else
    chk("bp_len", wlog.size() - base, 32'd34);
    chk("bp_trl", wlog[base+33], 32'h0000E020);
`endif

    // Reset on the tenth SCAN cycle.
    for (int k = 0; k < 32; k++) ev[8*k +: 8] = 8'(8'h20 + k);
    base = wlog.size();
    @(posedge clk100);
    #1 src_q.push_back(ev);
    wait_pop(20, "rst");
    repeat (10) @(posedge clk100);
    #1 rst = 1'b1;
    @(negedge clk100);
    chk("rst_words_before", wlog.size() - base, 32'd10);
    @(posedge clk100);
    #1;
    @(negedge clk100);
    chk("rst_busy_next", bus.busy, 32'd0);
    @(posedge clk100);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk100);
    chk("rst_no_writes", wlog.size() - base, 32'd10);
    base = wlog.size();
    #1 src_q.push_back(ev);
    wait_idle(200, "after_rst");
    chk("after_rst_hdr", wlog[base], 32'h0000A000);

    // 257 back-to-back events from a fresh reset.
    @(posedge clk100);
    #1 rst = 1'b1;
    @(posedge clk100);
    #1 rst = 1'b0;
    base = hdr_log.size();
    stream_mode = 1'b1;
    for (int i = 0; i < 257; i++) begin
      for (int k = 0; k < 32; k++) ev[8*k +: 8] = 8'(i * 7 + k * 13);
      src_q.push_back(ev);
    end
    wait_idle(257 * 35 + 200, "stream");
    stream_mode = 1'b0;
    chk("stream_hdrs",  hdr_log.size() - base, 32'd257);
    chk("stream_hdr0",  hdr_log[base],       32'h0000A000);
    chk("stream_hdrFF", hdr_log[base+255],   32'h0000A0FF);
    chk("stream_wrap",  hdr_log[base+256],   32'h0000A000);
    chk("stream_pops",  stream_pops,         32'd257);

    repeat (3) @(posedge clk100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
